// File: rtl/multi_button_autorepeat.sv
// Multi-channel push-button front end: per-channel synchronizer, debouncer and
// press / hold / auto-repeat pulse generator, plus a registered any-pulse flag.
module multi_button_autorepeat #(
    parameter int N_CH              = 4,
    parameter int N_DEBOUNCER_DELAY = 10,
    parameter int N_HOLD_DELAY      = 20,
    parameter int N_REPEAT_SLOW     = 5,
    parameter int N_REPEAT_FAST     = 2,
    parameter int N_ACCEL_COUNT     = 3
) (
    input  logic            clk,
    input  logic            resetN,
    input  logic [N_CH-1:0] PushButton,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] IncPulse_out,
    output logic [N_CH-1:0] BtnLevel_out,
    output logic            AnyPulse_out
);
    localparam int DW = $clog2(N_DEBOUNCER_DELAY + 1);
    localparam int HW = $clog2(N_HOLD_DELAY + 1);
    localparam int PW = $clog2(N_REPEAT_SLOW + 1);
    // Repeat count saturates one above N_ACCEL_COUNT, which marks fast mode.
    localparam int AW = $clog2(N_ACCEL_COUNT + 2);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HOLD   = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;
    localparam logic [1:0] S_LOCKED = 2'd3;

    logic any_q;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic          sync1_q, s_q;
        logic [DW-1:0] deb_cnt_q, deb_cnt_d;
        logic          level_q, level_d;
        logic [1:0]    state_q, state_d;
        logic [HW-1:0] hold_cnt_q, hold_cnt_d;
        logic [PW-1:0] per_cnt_q, per_cnt_d;
        logic [AW-1:0] rep_cnt_q, rep_cnt_d;
        logic          pulse_q, pulse_d;
        logic          rise, fall, fast;

        always_comb begin
            deb_cnt_d = '0;
            level_d   = level_q;
            if (s_q != level_q) begin
                if (deb_cnt_q == DW'(N_DEBOUNCER_DELAY - 1)) begin
                    level_d = ~level_q;
                end else begin
                    deb_cnt_d = deb_cnt_q + DW'(1);
                end
            end
        end

        assign rise = level_d & ~level_q;
        assign fall = ~level_d & level_q;
        assign fast = (rep_cnt_q > AW'(N_ACCEL_COUNT));

        // Release has priority over every other event, including a due pulse.
        always_comb begin
            state_d    = state_q;
            hold_cnt_d = hold_cnt_q;
            per_cnt_d  = per_cnt_q;
            rep_cnt_d  = rep_cnt_q;
            pulse_d    = 1'b0;
            if (fall) begin
                state_d    = S_IDLE;
                hold_cnt_d = '0;
                per_cnt_d  = '0;
                rep_cnt_d  = '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (rise) begin
                            pulse_d    = 1'b1;
                            hold_cnt_d = '0;
                            state_d    = repeat_en[c] ? S_HOLD : S_LOCKED;
                        end
                    end
                    S_HOLD: begin
                        if (!repeat_en[c]) begin
                            state_d    = S_LOCKED;
                            hold_cnt_d = '0;
                        end else if (hold_cnt_q == HW'(N_HOLD_DELAY - 1)) begin
                            pulse_d    = 1'b1;
                            state_d    = S_REPEAT;
                            hold_cnt_d = '0;
                            per_cnt_d  = '0;
                            rep_cnt_d  = AW'(1);
                        end else begin
                            hold_cnt_d = hold_cnt_q + HW'(1);
                        end
                    end
                    S_REPEAT: begin
                        if (!repeat_en[c]) begin
                            state_d   = S_LOCKED;
                            per_cnt_d = '0;
                            rep_cnt_d = '0;
                        end else if (per_cnt_q == (fast ? PW'(N_REPEAT_FAST - 1)
                                                        : PW'(N_REPEAT_SLOW - 1))) begin
                            pulse_d   = 1'b1;
                            per_cnt_d = '0;
                            if (!fast) rep_cnt_d = rep_cnt_q + AW'(1);
                        end else begin
                            per_cnt_d = per_cnt_q + PW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                sync1_q    <= 1'b0;
                s_q        <= 1'b0;
                deb_cnt_q  <= '0;
                level_q    <= 1'b0;
                state_q    <= S_IDLE;
                hold_cnt_q <= '0;
                per_cnt_q  <= '0;
                rep_cnt_q  <= '0;
                pulse_q    <= 1'b0;
            end else begin
                sync1_q    <= PushButton[c];
                s_q        <= sync1_q;
                deb_cnt_q  <= deb_cnt_d;
                level_q    <= level_d;
                state_q    <= state_d;
                hold_cnt_q <= hold_cnt_d;
                per_cnt_q  <= per_cnt_d;
                rep_cnt_q  <= rep_cnt_d;
                pulse_q    <= pulse_d;
            end
        end

        assign IncPulse_out[c] = pulse_q;
        assign BtnLevel_out[c] = level_q;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) any_q <= 1'b0;
        else         any_q <= |IncPulse_out;
    end

    assign AnyPulse_out = any_q;
endmodule

// File: tb/tb_multi_button_autorepeat.sv
// Bench for multi_button_autorepeat (2 channels, default timing): a per-cycle
// timing model feeds an expected queue, and per-scenario pulse counts come from a table.
module tb_multi_button_autorepeat;
    localparam int DEB     = 10;
    localparam int HOLD    = 20;
    localparam int SLOW    = 5;
    localparam int FASTP   = 2;
    localparam int ACCEL   = 3;
    localparam int T_PRESS = DEB + 2;
    localparam int T_HOLD  = T_PRESS + HOLD;
    localparam int T_FAST  = T_HOLD + SLOW * ACCEL;
    localparam int NONE    = 100000;

    logic       clk;
    logic       resetN;
    logic [1:0] PushButton;
    logic [1:0] repeat_en;
    logic [1:0] IncPulse_out;
    logic [1:0] BtnLevel_out;
    logic       AnyPulse_out;

    multi_button_autorepeat #(.N_CH(2)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .PushButton   (PushButton),
        .repeat_en    (repeat_en),
        .IncPulse_out (IncPulse_out),
        .BtnLevel_out (BtnLevel_out),
        .AnyPulse_out (AnyPulse_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mask;
        int         hold;
        logic [1:0] en;
        int         drop;
        int         cnt0;
        int         cnt1;
    } vec_t;

    vec_t       vt[8];
    int         t_now;
    int         st[2], pon[2], hd[2], dr[2];
    bit         enm[2];
    int         pcnt[2];
    int         errors, checks;
    logic [4:0] exp_q[$];

    // Expected pulse at relative time r for a press held h cycles.
    function automatic bit pulse_at(int r, int h, bit en, int d);
        if (h < DEB || r < 0 || r >= h + T_PRESS) return 1'b0;
        if (r == T_PRESS) return 1'b1;
        if (!en || r > d) return 1'b0;
        if (r == T_HOLD) return 1'b1;
        if (r > T_HOLD && r <= T_FAST && (r - T_HOLD) % SLOW == 0) return 1'b1;
        if (r > T_FAST && (r - T_FAST) % FASTP == 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_pulse(int c, int t);
        return pulse_at(t - st[c], hd[c], enm[c], dr[c]);
    endfunction

    function automatic bit exp_level(int c, int t);
        int r;
        r = t - st[c];
        return (hd[c] >= DEB) && (r >= T_PRESS) && (r < hd[c] + T_PRESS);
    endfunction

    function automatic logic [4:0] exp_vec(int t);
        return {exp_pulse(1, t), exp_pulse(0, t), exp_level(1, t), exp_level(0, t),
                exp_pulse(0, t - 1) | exp_pulse(1, t - 1)};
    endfunction

    task automatic sample_check();
        logic [4:0] e, got;
        got = {IncPulse_out, BtnLevel_out, AnyPulse_out};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_empty t=%0d got=%b expected an entry", t_now, got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL cycle t=%0d {inc,lvl,any} got=%b exp=%b", t_now, got, e);
            end
        end
        pcnt[0] += int'(IncPulse_out[0]);
        pcnt[1] += int'(IncPulse_out[1]);
    endtask

    task automatic drive_push();
        for (int c = 0; c < 2; c++) begin
            PushButton[c] = (t_now >= pon[c]) && (t_now < st[c] + hd[c]);
            repeat_en[c]  = enm[c] && !((t_now - st[c] >= dr[c]) && (t_now - st[c] < dr[c] + 10));
        end
        exp_q.push_back(exp_vec(t_now + 1));
        t_now++;
    endtask

    task automatic step();
        @(negedge clk);
        sample_check();
        drive_push();
    endtask

    task automatic check_int(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic check_zero(string name);
        checks++;
        if ({IncPulse_out, BtnLevel_out, AnyPulse_out} !== 5'b0) begin
            errors++;
            $display("FAIL %s got=%b exp=00000", name, {IncPulse_out, BtnLevel_out, AnyPulse_out});
        end
    endtask

    initial begin
        int base;
        errors = 0;
        checks = 0;
        t_now  = 0;
        for (int c = 0; c < 2; c++) begin
            st[c] = -NONE; pon[c] = -NONE; hd[c] = 0; dr[c] = NONE; enm[c] = 1'b0; pcnt[c] = 0;
        end
        // mask, hold, repeat_en, drop (relative), expected pulses ch0, ch1
        vt[0] = '{2'b01,   3, 2'b11, NONE,  0, 0};
        vt[1] = '{2'b01,   9, 2'b11, NONE,  0, 0};
        vt[2] = '{2'b01,  10, 2'b11, NONE,  1, 0};
        vt[3] = '{2'b01,  15, 2'b11, NONE,  1, 0};
        vt[4] = '{2'b01, 100, 2'b01, NONE, 37, 0};
        vt[5] = '{2'b11,  60, 2'b01, NONE, 17, 1};
        vt[6] = '{2'b01,  60, 2'b01,   40,  3, 0};
        vt[7] = '{2'b01,  40, 2'b01, NONE,  7, 0};

        resetN     = 1'b0;
        PushButton = 2'b00;
        repeat_en  = 2'b00;
        #1;
        check_zero("reset_state");
        @(negedge clk);
        resetN = 1'b1;
        drive_push();

        for (int i = 0; i < 8; i++) begin
            base = t_now + 3;
            for (int c = 0; c < 2; c++) begin
                if (vt[i].mask[c]) begin
                    st[c] = base; pon[c] = base; hd[c] = vt[i].hold;
                end else begin
                    st[c] = -NONE; pon[c] = -NONE; hd[c] = 0;
                end
                enm[c]  = vt[i].en[c];
                dr[c]   = vt[i].drop;
                pcnt[c] = 0;
            end
            while (t_now < base + vt[i].hold + 25) step();
            check_int($sformatf("pulses_ch0_vec%0d", i), pcnt[0], vt[i].cnt0);
            check_int($sformatf("pulses_ch1_vec%0d", i), pcnt[1], vt[i].cnt1);
        end

        // Reset while holding: async clear, then the held button re-presses.
        base = t_now + 3;
        st[0] = base; pon[0] = base; hd[0] = NONE; enm[0] = 1'b1; dr[0] = NONE;
        st[1] = -NONE; pon[1] = -NONE; hd[1] = 0; enm[1] = 1'b0;
        pcnt[0] = 0; pcnt[1] = 0;
        while (t_now < base + 45) step();
        @(negedge clk);
        sample_check();
        st[0] = base + 50;
        hd[0] = 20;
        resetN = 1'b0;
        #1;
        check_zero("async_reset");
        drive_push();
        while (t_now < base + 50) step();
        @(negedge clk);
        sample_check();
        resetN = 1'b1;
        drive_push();
        while (t_now < base + 100) step();
        check_int("pulses_reset_ch0", pcnt[0], 5);
        check_int("pulses_reset_ch1", pcnt[1], 0);

        @(negedge clk);
        sample_check();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
